// File: rtl/rgb_wheel_pwm.sv
// rgb_wheel_pwm: three-channel LED PWM with colour-wheel, static, off and breathe modes.
// Build with RGB_WHEEL_BREATH_EN defined to get the breathe level ramp; otherwise mode 11 acts as OFF.
//
// Colour handshake FSM
//   state    | meaning
//   ST_READY | color_ready high, a new static colour can be accepted
//   ST_APPLY | colour stored, waiting for the frame end that applies it
module rgb_wheel_pwm #(
  parameter int PWM_W   = 8,
  parameter int DIV     = 50000,
  parameter bit ACT_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             color_valid,
  output logic             color_ready,
  input  logic [PWM_W-1:0] color_r,
  input  logic [PWM_W-1:0] color_g,
  input  logic [PWM_W-1:0] color_b,
  output logic             r,
  output logic             g,
  output logic             b
);
  localparam int POS_W = PWM_W + 2;
  localparam int PRE_W = $clog2(DIV);

  localparam logic [1:0] MODE_WHEEL   = 2'b00;
  localparam logic [1:0] MODE_STATIC  = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  localparam logic [PWM_W-1:0] MAX       = '1;
  localparam logic [POS_W-1:0] MAX_P     = POS_W'((1 << PWM_W) - 1);
  localparam logic [POS_W-1:0] TWO_MAX   = POS_W'(2 * ((1 << PWM_W) - 1));
  localparam logic [POS_W-1:0] THREE_MAX = POS_W'(3 * ((1 << PWM_W) - 1));
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(3 * ((1 << PWM_W) - 1) - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_APPLY = 1'b1
  } hs_state_t;

  hs_state_t        state, state_nxt;
  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [PWM_W-1:0] cnt;
  logic             frame_end;
  logic [POS_W-1:0] pos;
  logic             xfer;
  logic [PWM_W-1:0] col_r, col_g, col_b;
  logic [PWM_W-1:0] duty_r, duty_g, duty_b;
  logic [PWM_W-1:0] whl_r, whl_g, whl_b;
  logic [PWM_W-1:0] tgt_r, tgt_g, tgt_b;

  assign tick      = (presc == PRE_LAST);
  assign frame_end = (cnt == MAX);
  assign xfer      = color_valid && color_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      cnt   <= cnt + 1'b1;
    end
  end

  // Wheel position only moves in WHEEL mode and is held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (tick && (mode == MODE_WHEEL)) begin
      pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
    end
  end

  always_comb begin
    whl_r = '0;
    whl_g = '0;
    whl_b = '0;
    if (pos < MAX_P) begin
      whl_r = PWM_W'(MAX_P - pos);
      whl_b = PWM_W'(pos);
    end else if (pos < TWO_MAX) begin
      whl_g = PWM_W'(pos - MAX_P);
      whl_b = PWM_W'(TWO_MAX - pos);
    end else begin
      whl_r = PWM_W'(pos - TWO_MAX);
      whl_g = PWM_W'(THREE_MAX - pos);
    end
  end

`ifdef RGB_WHEEL_BREATH_EN
  logic [PWM_W-1:0] level;
  logic             level_up;

  // Triangle ramp: both end values last exactly one tick before reversing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level    <= '0;
      level_up <= 1'b1;
    end else if (tick && (mode == MODE_BREATHE)) begin
      if (level_up && (level == MAX)) begin
        level    <= MAX - 1'b1;
        level_up <= 1'b0;
      end else if (!level_up && (level == '0)) begin
        level    <= PWM_W'(1);
        level_up <= 1'b1;
      end else if (level_up) begin
        level <= level + 1'b1;
      end else begin
        level <= level - 1'b1;
      end
    end
  end
`endif

  always_comb begin
    tgt_r = '0;
    tgt_g = '0;
    tgt_b = '0;
    case (mode)
      MODE_WHEEL: begin
        tgt_r = whl_r;
        tgt_g = whl_g;
        tgt_b = whl_b;
      end
      MODE_STATIC: begin
        tgt_r = col_r;
        tgt_g = col_g;
        tgt_b = col_b;
      end
`ifdef RGB_WHEEL_BREATH_EN
      MODE_BREATHE: begin
        tgt_r = PWM_W'(({{PWM_W{1'b0}}, col_r} * {{PWM_W{1'b0}}, level}) >> PWM_W);
        tgt_g = PWM_W'(({{PWM_W{1'b0}}, col_g} * {{PWM_W{1'b0}}, level}) >> PWM_W);
        tgt_b = PWM_W'(({{PWM_W{1'b0}}, col_b} * {{PWM_W{1'b0}}, level}) >> PWM_W);
      end
`else
      MODE_BREATHE: begin
        tgt_r = '0;
        tgt_g = '0;
        tgt_b = '0;
      end
`endif
      default: begin
        tgt_r = '0;
        tgt_g = '0;
        tgt_b = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= '0;
      col_g <= '0;
      col_b <= '0;
    end else if (xfer) begin
      col_r <= color_r;
      col_g <= color_g;
      col_b <= color_b;
    end
  end

  // Duties only change on the last count of a frame so a frame is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r <= '0;
      duty_g <= '0;
      duty_b <= '0;
    end else if (frame_end) begin
      duty_r <= tgt_r;
      duty_g <= tgt_g;
      duty_b <= tgt_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_READY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_READY: if (color_valid) state_nxt = ST_APPLY;
      ST_APPLY: if (frame_end) state_nxt = ST_READY;
      default:  state_nxt = ST_READY;
    endcase
  end

  always_comb begin
    color_ready = (state == ST_READY);
  end

  assign r = (cnt < duty_r) ^ ACT_LOW;
  assign g = (cnt < duty_g) ^ ACT_LOW;
  assign b = (cnt < duty_b) ^ ACT_LOW;

endmodule

// File: doc/rgb_wheel_pwm.md
RGB_WHEEL_PWM -- requirements
Module: rgb_wheel_pwm

Interface
REQ-001 SHALL have parameter PWM_W, default 8, meaning PWM/duty resolution in bits (MAX = 2^PWM_W-1).
REQ-002 SHALL have parameter DIV, default 50000, meaning clk cycles per animation step (DIV>=2).
REQ-003 SHALL have parameter ACT_LOW, default 1, meaning 1 = LED on when output is 0.
REQ-004 clk  in  1  single clock, all logic on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 mode  in  2  00 WHEEL, 01 STATIC, 10 OFF, 11 BREATHE.
REQ-007 color_valid  in  1  static colour offered.
REQ-008 color_ready  out  1  block can accept a colour.
REQ-009 color_r, color_g, color_b  in  PWM_W each  offered static colour.
REQ-010 r, g, b  out  1 each  PWM LED drives.

Function
REQ-011 Prescaler SHALL count 0..DIV-1, wrap to 0, and pulse an internal step tick for one cycle when the count equals DIV-1.
REQ-012 PWM counter SHALL be free-running, PWM_W bits, wrapping MAX->0; a frame ends on the cycle the counter equals MAX.
REQ-013 Each channel SHALL drive its active level while counter < active duty, else its inactive level; duty 0 = never on, duty MAX = on MAX of 2^PWM_W cycles.
REQ-014 Active duties SHALL load only at frame end from the target duties, so the PWM never glitches mid-frame.
REQ-015 WHEEL: on each tick pos SHALL advance by 1 and wrap 3*MAX-1 -> 0; pos is held, not reset, while in other modes.
REQ-016 WHEEL targets: pos<MAX: r=MAX-pos, g=0, b=pos; MAX<=pos<2*MAX: r=0, g=pos-MAX, b=2*MAX-pos; else r=pos-2*MAX, g=3*MAX-pos, b=0.
REQ-017 STATIC: targets SHALL equal the stored colour.
REQ-018 OFF: targets SHALL be 0.
REQ-019 Handshake: transfer occurs when color_valid && color_ready on a clock edge; stored colour updates on that edge.
REQ-020 color_ready SHALL fall for the cycle after a transfer and remain low until the next frame end has applied the new colour, then rise.
REQ-021 color_valid while color_ready is low SHALL be ignored; the offer must be held.
REQ-022 Mode SHALL be sampled every cycle; a change affects targets immediately and outputs at the next frame end.
REQ-023 Internal width for pos SHALL be PWM_W+2 bits; no arithmetic SHALL overflow for any PWM_W 4..12.

Reset
REQ-024 While rst_n=0: r, g, b at inactive level (1 if ACT_LOW), color_ready=1, prescaler, PWM counter, pos, level, stored colour and duties all 0.
REQ-025 Reset assertion mid-frame or mid-handshake SHALL abort immediately; a pending colour is discarded.
REQ-026 After rst_n rises, first PWM frame SHALL start with counter 0 on the first clk edge.

Configuration
REQ-027 With macro RGB_WHEEL_BREATH_EN defined, BREATHE SHALL ramp an internal level 0->MAX->0 by 1 per tick, reversing direction at both ends (level MAX and 0 each held for exactly one tick), targets = (stored colour * level) >> PWM_W per channel.
REQ-028 Without RGB_WHEEL_BREATH_EN, mode 11 SHALL behave exactly as OFF and no level logic SHALL be present.

Verification
REQ-029 PWM_W=8, DIV=4, mode=00 from reset -> r duty 255, b 0; after 255 ticks r=0,g=0,b=255; after 765 ticks pos wraps to 0.
REQ-030 mode=01, offer 0x80/0x00/0xFF -> transfer in one cycle, ready low until frame end, then r on 128/256 cycles, g never, b 255/256.
REQ-031 Change color mid-frame -> r/g/b waveform of the current frame unchanged; new duty from next counter=0.
REQ-032 Pull rst_n low mid-frame with pending colour -> outputs inactive same cycle, ready=1, stored colour 0.
REQ-033 mode=11, colour 0xFF/0xFF/0xFF, macro defined -> duty ramps 0..254..0 over 510 ticks; macro undefined -> all outputs inactive.
REQ-034 ACT_LOW=0 with duty 0 -> outputs constant 0; duty MAX -> 1 except one cycle per frame.
